// File: rtl/arcade_output_device.sv
// Decodes host OUT command bytes into set/clear/timed-pulse outputs and answers '?' with a state dump.
// Commands land one cycle after consume; the host is backpressured while the reply bytes are sent.
module arcade_output_device #(
  parameter int NUM_OUTPUTS = 8,
  parameter int PULSE_MS    = 50
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic [NUM_OUTPUTS-1:0] outputs_o,
  input  logic [10:0]            frame_i,
  output logic [7:0]             in_data_o,
  output logic                   in_valid_o,
  input  logic                   in_ready_i,
  input  logic [7:0]             out_data_i,
  input  logic                   out_valid_i,
  output logic                   out_ready_o,
  input  logic                   usb_configured_i
);
  localparam logic [7:0] PULSE8 = 8'(PULSE_MS);
  localparam logic [3:0] LAST   = 4'(NUM_OUTPUTS - 1);

  typedef enum logic {S_IDLE, S_REPLY} state_t;

  state_t                 r_state;
  logic [NUM_OUTPUTS-1:0] r_out;
  logic [NUM_OUTPUTS-1:0] r_snap;
  logic [7:0]             r_cnt [NUM_OUTPUTS];
  logic [3:0]             r_idx;
  logic [7:0]             r_in_data;
  logic                   r_in_valid;
  logic                   r_out_ready;
  logic                   r_beat;
  logic                   r_last_frame;

  logic [7:0]             w_off_set;
  logic [7:0]             w_off_clr;
  logic [7:0]             w_off_pls;
  logic [NUM_OUTPUTS-1:0] w_set;
  logic [NUM_OUTPUTS-1:0] w_clr;
  logic [NUM_OUTPUTS-1:0] w_pls;
  logic                   w_consume;
  logic                   w_query;
  logic                   w_unused;

  // Only the frame parity matters: each toggle is one ~1 ms beat.
  assign w_unused  = ^frame_i[10:1];
  assign w_consume = out_valid_i && r_out_ready;
  assign w_query   = w_consume && (out_data_i == 8'h3F);
  assign w_off_set = out_data_i - 8'h41;
  assign w_off_clr = out_data_i - 8'h61;
  assign w_off_pls = out_data_i - 8'h30;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    w_pls = '0;
    for (int n = 0; n < NUM_OUTPUTS; n++) begin
      w_set[n] = w_consume && (w_off_set == 8'(n));
      w_clr[n] = w_consume && (w_off_clr == 8'(n));
      w_pls[n] = w_consume && (w_off_pls == 8'(n));
    end
  end

  function automatic logic [7:0] reply_byte(input logic [NUM_OUTPUTS-1:0] s, input logic [3:0] i);
    logic b;
    b = 1'b0;
    for (int n = 0; n < NUM_OUTPUTS; n++) begin
      if (i == 4'(n)) b = s[n];
    end
    return b ? (8'h41 + {4'd0, i}) : (8'h61 + {4'd0, i});
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_out        <= '0;
      r_snap       <= '0;
      r_idx        <= '0;
      r_in_data    <= '0;
      r_in_valid   <= 1'b0;
      r_out_ready  <= 1'b0;
      r_beat       <= 1'b0;
      r_last_frame <= 1'b0;
      for (int n = 0; n < NUM_OUTPUTS; n++) r_cnt[n] <= '0;
    end else begin
      r_last_frame <= frame_i[0];
      r_beat       <= (frame_i[0] != r_last_frame);
      if (!usb_configured_i) begin
        // Unconfigured: drain host bytes without decoding and hold everything low.
        r_state     <= S_IDLE;
        r_out       <= '0;
        r_idx       <= '0;
        r_in_data   <= '0;
        r_in_valid  <= 1'b0;
        r_out_ready <= 1'b1;
        for (int n = 0; n < NUM_OUTPUTS; n++) r_cnt[n] <= '0;
      end else begin
        // Later assignments in this loop let a same-cycle command override the beat.
        for (int n = 0; n < NUM_OUTPUTS; n++) begin
          if (r_beat && (r_cnt[n] != 8'd0)) begin
            r_cnt[n] <= r_cnt[n] - 8'd1;
            if (r_cnt[n] == 8'd1) r_out[n] <= 1'b0;
          end
          if (w_set[n]) begin
            r_out[n] <= 1'b1;
            r_cnt[n] <= 8'd0;
          end else if (w_clr[n]) begin
            r_out[n] <= 1'b0;
            r_cnt[n] <= 8'd0;
          end else if (w_pls[n]) begin
            r_out[n] <= 1'b1;
            r_cnt[n] <= PULSE8;
          end
        end
        case (r_state)
          S_IDLE: begin
            r_out_ready <= 1'b1;
            if (w_query) begin
              r_snap      <= r_out;
              r_idx       <= 4'd0;
              r_in_data   <= reply_byte(r_out, 4'd0);
              r_in_valid  <= 1'b1;
              r_out_ready <= 1'b0;
              r_state     <= S_REPLY;
            end
          end
          S_REPLY: begin
            r_out_ready <= 1'b0;
            if (r_in_valid && in_ready_i) begin
              if (r_idx == LAST) begin
                r_in_valid  <= 1'b0;
                r_in_data   <= '0;
                r_out_ready <= 1'b1;
                r_state     <= S_IDLE;
              end else begin
                r_idx     <= r_idx + 4'd1;
                r_in_data <= reply_byte(r_snap, r_idx + 4'd1);
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign outputs_o   = r_out;
  assign in_data_o   = r_in_data;
  assign in_valid_o  = r_in_valid;
  assign out_ready_o = r_out_ready;

endmodule
